pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Owns the architectural PC register and drives the instruction-memory fetch handshake.
- Consumes the next-PC/redirect decision produced by the execute-stage next-PC mux.
- Delivers fetched instructions to decode over a valid/ready handshake.
- Sits at the front of the pipeline, between instruction memory and the IF/ID boundary.

Parameters:
- RESET_PC, 64'h0000_0000_0000_0000, PC value loaded on reset.
- INST_W, 32, instruction word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- redirect_valid  input  1  execute stage requests a PC change this cycle (taken branch/jump).
- redirect_pc  input  64  redirect target; bits [1:0] are ignored and treated as 0.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  64  fetch address; stable while imem_req=1 and no ack.
- imem_ack  input  1  single-cycle acknowledge; imem_rdata is valid in the same cycle.
- imem_rdata  input  INST_W  fetched instruction word.
- if_valid  output  1  instruction available to decode.
- if_ready  input  1  decode accepts the instruction (low = stall).
- if_pc  output  64  PC of the presented instruction.
- if_inst  output  INST_W  presented instruction word.

Behaviour:
- Reset (async, rst=1):
  - state=BOOT, pc=RESET_PC, pend_pc=0, inst_q=0.
  - Outputs: imem_req=0, if_valid=0, if_pc=RESET_PC, if_inst=0.
- States: BOOT, FETCH, HOLD, DROP.
  - imem_req = (state==FETCH or DROP).
  - imem_addr = pc.
  - if_pc = pc; if_inst = inst_q.
  - if_valid = (state==HOLD) and not redirect_valid.
- BOOT: unconditionally goes to FETCH next cycle. A redirect in BOOT loads pc=target and still goes to FETCH.
- FETCH:
  - imem_ack=1, no redirect: inst_q <= imem_rdata; state goes to HOLD.
  - imem_ack=1 and redirect_valid in the same cycle: data is discarded; pc <= target; state stays FETCH (new request next cycle).
  - imem_ack=0 and redirect_valid: pend_pc <= target; state goes to DROP. The outstanding request is never withdrawn, and address and req stay stable.
  - No ack, no redirect: state stays FETCH.
- DROP:
  - imem_req=1 with the old pc.
  - A redirect in DROP overwrites pend_pc (the last redirect wins, including in the ack cycle).
  - On imem_ack: data is discarded; pc <= (redirect_valid ? target : pend_pc); state goes to FETCH.
- HOLD:
  - redirect_valid: if_valid is forced 0 this cycle (squash wins over the handshake); pc <= target; state goes to FETCH.
  - else if_ready=1: pc <= pc+4 (64-bit wrap modulo 2^64); state goes to FETCH.
  - else: hold; if_pc and if_inst stay stable while if_valid=1.
- Latency:
  - Ack in cycle N gives if_valid in N+1.
  - Accept in cycle M gives imem_req for pc+4 in M+1.
  - Best-case throughput is one instruction per 2 cycles with a zero-wait memory.
- Invariants:
  - A response is never presented for an address older than the latest redirect.
  - imem_req never falls without an ack, except on rst.
  - imem_addr never changes while imem_req=1 and ack=0.
- Reset mid-operation: everything returns to reset values immediately. Any in-flight memory response is the memory's responsibility (memory is reset by the same rst).

Test Plan:
- Reset release, memory acks 1 cycle after req, if_ready=1 throughout -> fetch addresses 0x0, 0x4, 0x8 in order; if_pc/if_inst match; imem_req=0 in the first post-reset cycle.
- HOLD with if_inst=0x00000013 at if_pc=0x8, if_ready=0 for 5 cycles -> if_valid stays 1 with stable pc/inst and no new imem_req; if_ready=1 -> next req at 0xC.
- Redirect to 0x100 while FETCH at 0x10 is waiting (ack delayed 3 cycles) -> imem_addr holds 0x10 until ack, data is dropped, next req is at 0x100, and no instruction with if_pc=0x10 is delivered.
- Two redirects in DROP (0x200 then 0x300) -> after the stale ack, the next fetch is at 0x300.
- Redirect to 0x402 in HOLD with if_ready=1 same cycle -> if_valid=0 that cycle; next fetch at 0x400.
- Assert rst mid-DROP -> outputs reset immediately; after release, the first fetch is at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Front-end fetch unit: owns the architectural PC, issues instruction-memory
// requests and presents fetched words to decode over a valid/ready handshake.
module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter int          INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [63:0]       redirect_pc,
  output logic              imem_req,
  output logic [63:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [63:0]       if_pc,
  output logic [INST_W-1:0] if_inst
);

  // Handshakes: a memory request stays asserted with a stable address until
  // imem_ack; decode takes the word in a cycle where if_valid && if_ready.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [63:0]       pc;
  logic [63:0]       pend_pc;
  logic [63:0]       target;
  logic [INST_W-1:0] inst_q;

  assign target = {redirect_pc[63:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:  state_nxt = FETCH;
      FETCH: begin
        if (imem_ack && !redirect_valid) begin
          state_nxt = HOLD;
        end else if (!imem_ack && redirect_valid) begin
          state_nxt = DROP;
        end
      end
      HOLD:  if (redirect_valid || if_ready) state_nxt = FETCH;
      DROP:  if (imem_ack) state_nxt = FETCH;
      default: state_nxt = BOOT;
    endcase
  end

  // A redirect squashes the presented instruction in the same cycle.
  always_comb begin
    imem_req  = (state == FETCH) || (state == DROP);
    imem_addr = pc;
    if_valid  = (state == HOLD) && !redirect_valid;
    if_pc     = pc;
    if_inst   = inst_q;
  end

  // In DROP the request for the old pc is still outstanding; the newest
  // redirect target is parked in pend_pc until the stale response arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      pend_pc <= 64'h0;
      inst_q  <= '0;
    end else begin
      case (state)
        BOOT: begin
          if (redirect_valid) pc <= target;
        end
        FETCH: begin
          if (imem_ack) begin
            if (redirect_valid) begin
              pc <= target;
            end else begin
              inst_q <= imem_rdata;
            end
          end else if (redirect_valid) begin
            pend_pc <= target;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc <= target;
          end else if (if_ready) begin
            pc <= pc + 64'd4;
          end
        end
        DROP: begin
          if (redirect_valid) pend_pc <= target;
          if (imem_ack) pc <= redirect_valid ? target : pend_pc;
        end
        default: ;
      endcase
    end
  end

endmodule
